// File: rtl/fg_prog_sequencer_pkg.sv
// Shared types and defaults for the floating-gate programming sequencer.
package fg_prog_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_SETTLE,
        S_HOLD,
        S_RESP
    } state_t;

    localparam logic MODE_PROG = 1'b0;
    localparam logic MODE_READ = 1'b1;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 8;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 3;
    localparam int TMR_W    = 16;

    // A state lasting n cycles loads n-1 into the timer on entry.
    function automatic logic [TMR_W-1:0] dur(input int n);
        return (n <= 1) ? '0 : TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/fg_prog_sequencer_if.sv
// Host command/response and programming-mux bundle; cmd_target exists only with FG_PROG_VERIFY_EN.
interface fg_prog_sequencer_if #(
    parameter int NUM_ISL = 2,
    parameter int MEAS_W  = 12
);
    localparam int ISL_W = (NUM_ISL > 1) ? $clog2(NUM_ISL) : 1;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_mode;
    logic [ISL_W-1:0]   cmd_island;
    logic [1:0]         cmd_row;
    logic [2:0]         cmd_col;
    logic [15:0]        cmd_pulse_len;
    logic [7:0]         cmd_pulse_cnt;
`ifdef FG_PROG_VERIFY_EN
    logic [MEAS_W-1:0]  cmd_target;
`endif
    logic               abort;
    logic [MEAS_W-1:0]  meas_in;
    logic [NUM_ISL-1:0] isl_sel;
    logic [2:0]         gate_addr;
    logic [1:0]         drain_addr;
    logic               gate_en;
    logic               drain_en;
    logic               prog_en;
    logic               busy;
    logic               rsp_valid;
    logic               rsp_err;
    logic [MEAS_W-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_mode, cmd_island, cmd_row, cmd_col,
               cmd_pulse_len, cmd_pulse_cnt, abort, meas_in,
`ifdef FG_PROG_VERIFY_EN
               cmd_target,
`endif
        input  cmd_ready, isl_sel, gate_addr, drain_addr, gate_en, drain_en,
               prog_en, busy, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_island, cmd_row, cmd_col,
               cmd_pulse_len, cmd_pulse_cnt, abort, meas_in,
`ifdef FG_PROG_VERIFY_EN
               cmd_target,
`endif
        output cmd_ready, isl_sel, gate_addr, drain_addr, gate_en, drain_en,
               prog_en, busy, rsp_valid, rsp_err, rsp_data
    );

endinterface

// File: rtl/fg_prog_sequencer_timer.sv
// Loadable down-counter shared by all timed sequencer states; o_zero marks the last cycle.
module fg_prog_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fg_prog_sequencer.sv
// FG program/readback sequencer: one command in flight, all outputs registered from next state.
// Optional FG_PROG_VERIFY_EN adds a verify read after each pulse with early stop at cmd_target.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int NUM_ISL    = 2,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int SETUP_CYC  = 4,
    parameter int HOLD_CYC   = 4,
    parameter int GAP_CYC    = 8,
    parameter int SETTLE_CYC = 16,
    parameter int MEAS_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    fg_prog_sequencer_if.slave bus
);
    state_t             r_state, w_nxt;
    logic               r_mode, r_err;
    logic [15:0]        r_len;
    logic [7:0]         r_rem;
`ifdef FG_PROG_VERIFY_EN
    logic [MEAS_W-1:0]  r_target;
`endif
    logic [NUM_ISL-1:0] r_isl_sel;
    logic [COL_W-1:0]   r_gate_addr;
    logic [ROW_W-1:0]   r_drain_addr;
    logic               r_gate_en, r_drain_en, r_prog_en;
    logic               r_busy, r_ready, r_rsp_valid, r_rsp_err;
    logic [MEAS_W-1:0]  r_rsp_data;

    logic               w_acc, w_oor, w_abort, w_tz, w_ld, w_dec, w_sample;
    logic [TMR_W-1:0]   w_ld_val, w_pdur;

    assign w_acc   = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_oor   = (32'(bus.cmd_island) >= NUM_ISL) || (32'(bus.cmd_row) >= ROWS) ||
                     (32'(bus.cmd_col) >= COLS);
    assign w_abort = bus.abort && (r_state inside {S_SETUP, S_PULSE, S_GAP, S_SETTLE});
    assign w_pdur  = (r_len == 16'd0) ? 16'd0 : r_len - 16'd1;

    fg_prog_timer #(.W(TMR_W)) u_tmr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_ld),
        .i_val  (w_ld_val),
        .o_zero (w_tz)
    );

    always_comb begin
        w_nxt    = r_state;
        w_dec    = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            S_IDLE:   if (w_acc) w_nxt = w_oor ? S_RESP : S_SETUP;
            S_SETUP:  if (w_tz) begin
                          if (r_mode == MODE_READ) w_nxt = S_SETTLE;
                          else                     w_nxt = (r_rem == 8'd0) ? S_HOLD : S_PULSE;
                      end
            S_PULSE:  if (w_tz) begin
                          w_dec = 1'b1;
`ifdef FG_PROG_VERIFY_EN
                          w_nxt = S_SETTLE;
`else
                          w_nxt = (r_rem > 8'd1) ? S_GAP : S_HOLD;
`endif
                      end
            S_GAP:    if (w_tz) w_nxt = S_PULSE;
            S_SETTLE: if (w_tz) begin
                          w_sample = 1'b1;
                          w_nxt    = S_HOLD;
`ifdef FG_PROG_VERIFY_EN
                          // r_rem was already decremented when the pulse ended
                          if (r_mode == MODE_PROG && r_rem != 8'd0 && bus.meas_in < r_target)
                              w_nxt = S_GAP;
`endif
                      end
            S_HOLD:   if (w_tz) w_nxt = S_RESP;
            S_RESP:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_nxt    = S_HOLD;
            w_sample = 1'b0;
        end
    end

    always_comb begin
        w_ld     = (w_nxt != r_state);
        w_ld_val = '0;
        case (w_nxt)
            S_SETUP:  w_ld_val = dur(SETUP_CYC);
            S_PULSE:  w_ld_val = w_pdur;
            S_GAP:    w_ld_val = dur(GAP_CYC);
            S_SETTLE: w_ld_val = dur(SETTLE_CYC);
            S_HOLD:   w_ld_val = dur(HOLD_CYC);
            default:  w_ld_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= MODE_PROG;
            r_err        <= 1'b0;
            r_len        <= '0;
            r_rem        <= '0;
`ifdef FG_PROG_VERIFY_EN
            r_target     <= '0;
`endif
            r_isl_sel    <= '0;
            r_gate_addr  <= '0;
            r_drain_addr <= '0;
            r_gate_en    <= 1'b0;
            r_drain_en   <= 1'b0;
            r_prog_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_acc) begin
                r_mode     <= bus.cmd_mode;
                r_err      <= w_oor;
                r_len      <= bus.cmd_pulse_len;
                r_rem      <= bus.cmd_pulse_cnt;
                r_rsp_data <= '0;
`ifdef FG_PROG_VERIFY_EN
                r_target   <= bus.cmd_target;
`endif
            end
            if (w_dec)    r_rem      <= r_rem - 8'd1;
            if (w_abort)  r_err      <= 1'b1;
            if (w_sample) r_rsp_data <= bus.meas_in;
            // Addresses load only on a valid accept and release only once HOLD has elapsed
            if (w_acc && !w_oor) begin
                r_isl_sel    <= NUM_ISL'(1) << bus.cmd_island;
                r_gate_addr  <= bus.cmd_col;
                r_drain_addr <= bus.cmd_row;
            end else if (w_nxt == S_RESP || w_nxt == S_IDLE) begin
                r_isl_sel    <= '0;
                r_gate_addr  <= '0;
                r_drain_addr <= '0;
            end
            r_gate_en   <= (w_nxt inside {S_PULSE, S_GAP, S_SETTLE});
            r_drain_en  <= (w_nxt inside {S_PULSE, S_GAP, S_SETTLE});
            r_prog_en   <= (w_nxt == S_PULSE);
            r_busy      <= (w_nxt != S_IDLE);
            r_ready     <= (w_nxt == S_IDLE);
            r_rsp_valid <= (w_nxt == S_RESP);
            r_rsp_err   <= (w_nxt == S_RESP) && (w_acc ? w_oor : r_err);
        end
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.isl_sel    = r_isl_sel;
    assign bus.gate_addr  = r_gate_addr;
    assign bus.drain_addr = r_drain_addr;
    assign bus.gate_en    = r_gate_en;
    assign bus.drain_en   = r_drain_en;
    assign bus.prog_en    = r_prog_en;
    assign bus.busy       = r_busy;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_data   = r_rsp_data;
endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Scoreboard bench for fg_prog_sequencer: expected responses queued at issue, compared on rsp_valid.
module tb_fg_prog_sequencer;
    import fg_prog_pkg::*;

    localparam int T_SETUP = 4, T_HOLD = 4, T_GAP = 8, T_SETTLE = 16;

    typedef struct {
        logic        err;
        logic [11:0] data;
        int          lat;
        int          pcyc;
        int          prise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fg_prog_sequencer_if #(.NUM_ISL(2), .MEAS_W(12)) bus ();
    fg_prog_sequencer_if #(.NUM_ISL(2), .MEAS_W(12)) bus6 ();

    fg_prog_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus));
    fg_prog_sequencer #(.COLS(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cyc = 0;
    int   p_cyc = 0, p_rise = 0, viol = 0;
    int   b_cyc = 0, b_rise = 0, b_viol = 0;
    logic prev_p = 1'b0, prev_en = 1'b0;
    logic [6:0] prev_addr = '0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Address/enable observer: addresses may only move with every enable low before and after
    always @(negedge clk) begin
        logic cur_en;
        cur_en = bus.gate_en | bus.drain_en | bus.prog_en;
        if (bus.prog_en) p_cyc++;
        if (bus.prog_en && !prev_p) p_rise++;
        if ({bus.isl_sel, bus.gate_addr, bus.drain_addr} != prev_addr && (cur_en || prev_en)) viol++;
        if (bus.prog_en && !(bus.gate_en && bus.drain_en)) viol++;
        prev_p    = bus.prog_en;
        prev_en   = cur_en;
        prev_addr = {bus.isl_sel, bus.gate_addr, bus.drain_addr};
    end

    function automatic exp_t mk(input logic mode, input int len, input int cnt, input logic [11:0] meas);
        exp_t e;
        int   p;
        p     = (len == 0) ? 1 : len;
        e.err = 1'b0;
        if (mode == MODE_READ) begin
            e.data = meas; e.lat = T_SETUP + T_SETTLE + T_HOLD; e.pcyc = 0; e.prise = 0;
        end else begin
            e.data  = 12'h000;
            e.lat   = T_SETUP + cnt * p + ((cnt > 0) ? (cnt - 1) * T_GAP : 0) + T_HOLD;
            e.pcyc  = cnt * p;
            e.prise = cnt;
        end
        return e;
    endfunction

    task automatic issue(input logic mode, input logic isl, input logic [1:0] row, input logic [2:0] col,
                         input logic [15:0] len, input logic [7:0] cnt, input logic [11:0] meas, input exp_t e);
        @(negedge clk);
        chk("ready_before_issue", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_mode = mode; bus.cmd_island = isl; bus.cmd_row = row; bus.cmd_col = col;
        bus.cmd_pulse_len = len; bus.cmd_pulse_cnt = cnt; bus.meas_in = meas;
        bus.cmd_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
        b_cyc = p_cyc; b_rise = p_rise; b_viol = viol;
    endtask

    task automatic wait_rsp();
        exp_t e;
        int   n;
        n = 0;
        while (!bus.rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        if (!bus.rsp_valid || sb.size() == 0) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk("rsp_err",     32'(bus.rsp_err), 32'(e.err));
        chk("rsp_data",    32'(bus.rsp_data), 32'(e.data));
        chk("latency",     32'(cyc - acc_cyc), 32'(e.lat));
        chk("prog_cycles", 32'(p_cyc - b_cyc), 32'(e.pcyc));
        chk("pulses",      32'(p_rise - b_rise), 32'(e.prise));
        chk("addr_stable", 32'(viol - b_viol), 32'd0);
        chk("isl_cleared", 32'(bus.isl_sel), 32'd0);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        chk("ready_after",   32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   n;
        logic seen_en, got, got_err;

        bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_island = 0; bus.cmd_row = 0; bus.cmd_col = 0;
        bus.cmd_pulse_len = 0; bus.cmd_pulse_cnt = 0; bus.abort = 0; bus.meas_in = 0;
        bus6.cmd_valid = 0; bus6.cmd_mode = 0; bus6.cmd_island = 0; bus6.cmd_row = 0; bus6.cmd_col = 0;
        bus6.cmd_pulse_len = 0; bus6.cmd_pulse_cnt = 0; bus6.abort = 0; bus6.meas_in = 0;

        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_enables", 32'({bus.gate_en, bus.drain_en, bus.prog_en}), 32'd0);
        chk("rst_isl",    32'(bus.isl_sel), 32'd0);
        chk("rst_rsp",    32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 32'd0);
        rst = 1'b0;

        // Program island 1, row 2, col 5, two 3-cycle pulses
        issue(MODE_PROG, 1'b1, 2'd2, 3'd5, 16'd3, 8'd2, 12'h155, mk(MODE_PROG, 3, 2, 12'h155));
        chk("isl_sel",    32'(bus.isl_sel), 32'h2);
        chk("gate_addr",  32'(bus.gate_addr), 32'd5);
        chk("drain_addr", 32'(bus.drain_addr), 32'd2);
        chk("setup_no_en", 32'({bus.gate_en, bus.drain_en, bus.prog_en}), 32'd0);
        chk("busy",       32'(bus.busy), 32'd1);
        wait_rsp();

        // Readback island 0, row 3, col 7
        issue(MODE_READ, 1'b0, 2'd3, 3'd7, 16'd9, 8'd4, 12'h2A5, mk(MODE_READ, 9, 4, 12'h2A5));
        wait_rsp();

        // Boundary pulse shapes: zero pulses, and zero length treated as one cycle
        issue(MODE_PROG, 1'b0, 2'd1, 3'd1, 16'd5, 8'd0, 12'h0FF, mk(MODE_PROG, 5, 0, 12'h0FF));
        wait_rsp();
        issue(MODE_PROG, 1'b1, 2'd0, 3'd0, 16'd0, 8'd1, 12'h0FF, mk(MODE_PROG, 0, 1, 12'h0FF));
        wait_rsp();

        for (int i = 0; i < 5; i++) begin
            logic        m;
            int          l, c;
            logic [11:0] mv;
            m  = 1'($urandom_range(1));
            l  = $urandom_range(4);
            c  = $urandom_range(3);
            mv = 12'($urandom);
            issue(m, 1'($urandom_range(1)), 2'($urandom_range(3)), 3'($urandom_range(7)),
                  16'(l), 8'(c), mv, mk(m, l, c, mv));
            wait_rsp();
        end

        // Abort on the first cycle of the second pulse
        e = mk(MODE_PROG, 3, 3, 12'h0);
        e.err = 1'b1; e.lat = T_SETUP + 3 + T_GAP + 1 + T_HOLD; e.pcyc = 4; e.prise = 2;
        issue(MODE_PROG, 1'b0, 2'd3, 3'd2, 16'd3, 8'd3, 12'h0, e);
        n = 0;
        while (!bus.prog_en && n < 100) begin @(negedge clk); n++; end
        while (bus.prog_en && n < 100) begin @(negedge clk); n++; end
        while (!bus.prog_en && n < 100) begin @(negedge clk); n++; end
        chk("second_pulse_seen", 32'(bus.prog_en), 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_enables_low", 32'({bus.gate_en, bus.drain_en, bus.prog_en}), 32'd0);
        chk("abort_addr_held", 32'({bus.isl_sel, bus.gate_addr, bus.drain_addr}), 32'({2'b01, 3'd2, 2'd3}));
        wait_rsp();

        // Abort while idle is ignored
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'({bus.busy, bus.rsp_valid}), 32'd0);

        // Reset in the middle of a long pulse
        issue(MODE_PROG, 1'b1, 2'd1, 3'd6, 16'd20, 8'd1, 12'h0, mk(MODE_PROG, 20, 1, 12'h0));
        n = 0;
        while (!bus.prog_en && n < 100) begin @(negedge clk); n++; end
        chk("long_pulse_seen", 32'(bus.prog_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_enables", 32'({bus.gate_en, bus.drain_en, bus.prog_en}), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);

        // Column out of range on a 6-column build
        @(negedge clk);
        bus6.cmd_mode = MODE_PROG; bus6.cmd_island = 1'b0; bus6.cmd_row = 2'd1; bus6.cmd_col = 3'd7;
        bus6.cmd_pulse_len = 16'd2; bus6.cmd_pulse_cnt = 8'd1; bus6.cmd_valid = 1'b1;
        seen_en = 1'b0; got = 1'b0; got_err = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus6.cmd_valid = 1'b0;
            if (bus6.gate_en || bus6.drain_en || bus6.prog_en || bus6.isl_sel != 2'b00) seen_en = 1'b1;
            if (bus6.rsp_valid && !got) begin got = 1'b1; got_err = bus6.rsp_err; end
        end
        chk("oor_rsp_seen", 32'(got), 32'd1);
        chk("oor_rsp_err",  32'(got_err), 32'd1);
        chk("oor_no_drive", 32'(seen_en), 32'd0);
        chk("oor_ready",    32'(bus6.cmd_ready), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
